neuai_bcd_seg_counter: RTL and testbench

- Parametrised N-digit BCD seconds counter with registered 7-segment encoding for every digit in parallel.
- Adds over the single-digit 0–9 counter: up/down direction, parallel preset load, run/pause/done control FSM, wrap-or-stop mode, terminal-count pulse, optional leading-zero blanking, dp heartbeat.
- Sits after the 1 s divider; drives the board's 7-seg segment bus(es) directly.

---
 rtl/neuai_seg_pkg.sv | 27 ++
 rtl/neuai_seg7_enc.sv | 28 ++
 rtl/neuai_bcd_seg_counter.sv | 207 ++++++++++++++++++++
 tb/tb_neuai_bcd_seg_counter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuai_seg_pkg.sv
// Shared definitions for the BCD seconds counter:
// segment codes, blank code, FSM state type and a BCD clamp helper.
package neuai_seg_pkg;

    // Control FSM states; encodings are visible on o_state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Active-high segment codes, bit order p g f e d c b a (dp clear).
    localparam logic [7:0] SEG_CODE [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    // Active-high code of a dark digit (dp included).
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Saturate a nibble to a legal BCD digit.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/neuai_seg7_enc.sv
// Combinational single-digit 7-segment encoder with blanking and dp.
// Output polarity is selected by SEG_ACT_LOW and applies after blanking.
module neuai_seg7_enc
    import neuai_seg_pkg::*;
#(
    parameter bit SEG_ACT_LOW = 1'b0
) (
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    logic [7:0] raw;

    // Look up the digit pattern, overlay dp, then apply output polarity.
    always_comb begin
        raw = SEG_BLANK;
        if (!blank_i) begin
            if (bcd_i <= 4'd9) begin
                raw = SEG_CODE[bcd_i];
            end
            raw[7] = dp_i;
        end
        seg_o = SEG_ACT_LOW ? ~raw : raw;
    end

endmodule

// File: rtl/neuai_bcd_seg_counter.sv
// N-digit BCD seconds counter with run/pause/done control, preset load,
// wrap-or-stop terminal handling and registered per-digit 7-seg outputs.
module neuai_bcd_seg_counter
    import neuai_seg_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 2,
    parameter bit          WRAP_EN     = 1'b1,
    parameter bit          SEG_ACT_LOW = 1'b0,
    parameter bit          LZB_EN      = 1'b0
) (
    input  logic                    w_clk_1s,
    input  logic                    w_rst,
    input  logic                    i_start,
    input  logic                    i_pause,
    input  logic                    i_dir,
    input  logic                    i_load,
    input  logic [4*N_DIGITS-1:0]   i_load_bcd,
    output logic [4*N_DIGITS-1:0]   o_bcd,
    output logic [8*N_DIGITS-1:0]   o_seg,
    output logic                    o_tc,
    output logic [1:0]              o_state
);

    localparam int unsigned BW = 4 * N_DIGITS;
    localparam int unsigned SW = 8 * N_DIGITS;
    localparam logic [7:0]  BLANK_OUT = SEG_ACT_LOW ? ~SEG_BLANK : SEG_BLANK;

    state_e          state_q, state_d;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   preset_q, preset_d;
    logic            tc_q, tc_d;
    logic            hb_q, hb_d;
    logic [SW-1:0]   seg_q, seg_d;

    logic [BW-1:0]   load_cl;
    logic [BW-1:0]   cnt_up, cnt_dn, step_val;
    logic            all_nine, all_zero, term;
    logic [N_DIGITS-1:0] blank, dp;

    // Clamp each preset nibble to 0..9.
    always_comb begin
        load_cl = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            load_cl[4*k +: 4] = bcd_clamp(i_load_bcd[4*k +: 4]);
        end
    end

    // Ripple-carry increment and ripple-borrow decrement of the count,
    // plus terminal detection for both directions.
    always_comb begin : p_step
        logic       carry;
        logic       borrow;
        logic [3:0] dig;
        cnt_up   = '0;
        cnt_dn   = '0;
        all_nine = 1'b1;
        all_zero = 1'b1;
        carry    = 1'b1;
        borrow   = 1'b1;
        dig      = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            dig      = cnt_q[4*k +: 4];
            all_nine = all_nine & (dig == 4'd9);
            all_zero = all_zero & (dig == 4'd0);
            if (carry) begin
                if (dig == 4'd9) begin
                    cnt_up[4*k +: 4] = 4'd0;
                end else begin
                    cnt_up[4*k +: 4] = dig + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                cnt_up[4*k +: 4] = dig;
            end
            if (borrow) begin
                if (dig == 4'd0) begin
                    cnt_dn[4*k +: 4] = 4'd9;
                end else begin
                    cnt_dn[4*k +: 4] = dig - 4'd1;
                    borrow = 1'b0;
                end
            end else begin
                cnt_dn[4*k +: 4] = dig;
            end
        end
        term     = i_dir ? all_nine : all_zero;
        step_val = i_dir ? cnt_up : cnt_dn;
    end

    // Control FSM and count/preset next-state; load outranks start,
    // start outranks pause.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        preset_d = preset_q;
        tc_d     = 1'b0;
        hb_d     = hb_q;
        case (state_q)
            ST_IDLE: begin
                if (i_load) begin
                    cnt_d    = load_cl;
                    preset_d = load_cl;
                end else if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                hb_d = ~hb_q;
                // Load is ignored here, so start is the top live request
                // and keeps the counter running even if pause is also high.
                if (i_start || !i_pause) begin
                    if (term) begin
                        tc_d = 1'b1;
                        if (WRAP_EN) begin
                            cnt_d = step_val;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = step_val;
                    end
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (i_load) begin
                    cnt_d    = load_cl;
                    preset_d = load_cl;
                end else if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (i_load) begin
                    cnt_d    = load_cl;
                    preset_d = load_cl;
                    state_d  = ST_IDLE;
                end else if (i_start) begin
                    cnt_d   = preset_q;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Leading-zero blanking and dp heartbeat, derived from next-state values
    // so the registered segments line up with the registered count.
    always_comb begin : p_decor
        logic            hz;
        logic            dz;
        int unsigned     k;
        blank = '0;
        dp    = '0;
        hz    = 1'b1;
        dz    = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            k  = N_DIGITS - 1 - i;
            dz = (cnt_d[4*k +: 4] == 4'd0);
            if (LZB_EN && (k != 0) && hz && dz) begin
                blank[k] = 1'b1;
            end
            hz = hz & dz;
        end
        dp[0] = (state_d == ST_RUN) & hb_d;
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_enc
        neuai_seg7_enc #(
            .SEG_ACT_LOW (SEG_ACT_LOW)
        ) u_enc (
            .bcd_i   (cnt_d[4*g +: 4]),
            .blank_i (blank[g]),
            .dp_i    (dp[g]),
            .seg_o   (seg_d[8*g +: 8])
        );
    end

    // State, count, preset, pulse and segment registers.
    always_ff @(posedge w_clk_1s or negedge w_rst) begin
        if (!w_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            preset_q <= '0;
            tc_q     <= 1'b0;
            hb_q     <= 1'b0;
            seg_q    <= {N_DIGITS{BLANK_OUT}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            preset_q <= preset_d;
            tc_q     <= tc_d;
            hb_q     <= hb_d;
            seg_q    <= seg_d;
        end
    end

    assign o_bcd   = cnt_q;
    assign o_seg   = seg_q;
    assign o_tc    = tc_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_neuai_bcd_seg_counter.sv
// Bench for neuai_bcd_seg_counter: two instances (wrap/active-high and
// stop/active-low/blanking) share stimulus and are compared each cycle
// against an integer-valued reference model.
`timescale 1ns/1ps
module tb_neuai_bcd_seg_counter;

    localparam int ND   = 2;
    localparam int MAXV = 99;

    logic clk = 1'b0;
    logic w_rst = 1'b1;
    logic i_start = 1'b0, i_pause = 1'b0, i_dir = 1'b0, i_load = 1'b0;
    logic [4*ND-1:0] i_load_bcd = '0;

    logic [4*ND-1:0] bcd_o [2];
    logic [8*ND-1:0] seg_o [2];
    logic            tc_o  [2];
    logic [1:0]      st_o  [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] SEG_TBL [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    // reference model state per instance
    int m_val [2];
    int m_pre [2];
    int m_st  [2];
    bit m_par [2];
    bit m_tc  [2];
    bit m_segv[2];

    always #5 clk = ~clk;

    neuai_bcd_seg_counter #(
        .N_DIGITS(ND), .WRAP_EN(1'b1), .SEG_ACT_LOW(1'b0), .LZB_EN(1'b0)
    ) u0 (
        .w_clk_1s(clk), .w_rst(w_rst), .i_start(i_start), .i_pause(i_pause),
        .i_dir(i_dir), .i_load(i_load), .i_load_bcd(i_load_bcd),
        .o_bcd(bcd_o[0]), .o_seg(seg_o[0]), .o_tc(tc_o[0]), .o_state(st_o[0])
    );

    neuai_bcd_seg_counter #(
        .N_DIGITS(ND), .WRAP_EN(1'b0), .SEG_ACT_LOW(1'b1), .LZB_EN(1'b1)
    ) u1 (
        .w_clk_1s(clk), .w_rst(w_rst), .i_start(i_start), .i_pause(i_pause),
        .i_dir(i_dir), .i_load(i_load), .i_load_bcd(i_load_bcd),
        .o_bcd(bcd_o[1]), .o_seg(seg_o[1]), .o_tc(tc_o[1]), .o_state(st_o[1])
    );

    function automatic int clamp_val(input logic [4*ND-1:0] lb);
        int v = 0;
        int p = 1;
        int d;
        for (int k = 0; k < ND; k++) begin
            d = int'(lb[4*k +: 4]);
            if (d > 9) d = 9;
            v += d * p;
            p *= 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_val[i] = 0; m_pre[i] = 0; m_st[i] = 0;
            m_par[i] = 1'b0; m_tc[i] = 1'b0; m_segv[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic st, input logic pa, input logic di,
                              input logic ld, input logic [4*ND-1:0] lb);
        int  lv;
        bit  wrap;
        lv = clamp_val(lb);
        for (int i = 0; i < 2; i++) begin
            wrap = (i == 0);
            m_tc[i] = 1'b0;
            case (m_st[i])
                0: if (ld) begin m_val[i] = lv; m_pre[i] = lv; end
                   else if (st) m_st[i] = 1;
                1: begin
                    m_par[i] = ~m_par[i];
                    if (st || !pa) begin
                        if (di && m_val[i] == MAXV) begin
                            m_tc[i] = 1'b1;
                            if (wrap) m_val[i] = 0; else m_st[i] = 3;
                        end else if (!di && m_val[i] == 0) begin
                            m_tc[i] = 1'b1;
                            if (wrap) m_val[i] = MAXV; else m_st[i] = 3;
                        end else begin
                            m_val[i] = di ? m_val[i] + 1 : m_val[i] - 1;
                        end
                    end else begin
                        m_st[i] = 2;
                    end
                end
                2: if (ld) begin m_val[i] = lv; m_pre[i] = lv; end
                   else if (st) m_st[i] = 1;
                default: if (ld) begin m_val[i] = lv; m_pre[i] = lv; m_st[i] = 0; end
                   else if (st) begin m_val[i] = m_pre[i]; m_st[i] = 1; end
            endcase
            m_segv[i] = 1'b1;
        end
    endtask

    function automatic logic [4*ND-1:0] exp_bcd(input int i);
        logic [4*ND-1:0] r = '0;
        int v = m_val[i];
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [8*ND-1:0] exp_seg(input int i);
        logic [8*ND-1:0] r = '0;
        logic [7:0] s;
        int p = 1;
        for (int k = 0; k < ND; k++) begin
            if (!m_segv[i]) s = 8'h00;
            else if (i == 1 && k > 0 && m_val[i] < p) s = 8'h00;
            else begin
                s = SEG_TBL[(m_val[i] / p) % 10];
                if (k == 0 && m_st[i] == 1 && m_par[i]) s[7] = 1'b1;
            end
            if (i == 1) s = ~s;
            r[8*k +: 8] = s;
            p *= 10;
        end
        return r;
    endfunction

    task automatic cycle(input logic st, input logic pa, input logic di,
                         input logic ld, input logic [4*ND-1:0] lb);
        i_start = st; i_pause = pa; i_dir = di; i_load = ld; i_load_bcd = lb;
        @(posedge clk);
        model_edge(st, pa, di, ld, lb);
        #1;
    endtask

    task automatic test_reset();
        #1 w_rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (bcd_o[i] !== exp_bcd(i)) begin errors++; $display("FAIL reset u%0d bcd got %h want %h", i, bcd_o[i], exp_bcd(i)); end
            checks++; if (seg_o[i] !== exp_seg(i)) begin errors++; $display("FAIL reset u%0d seg got %h want %h", i, seg_o[i], exp_seg(i)); end
            checks++; if (tc_o[i] !== 1'b0) begin errors++; $display("FAIL reset u%0d tc got %b want 0", i, tc_o[i]); end
            checks++; if (st_o[i] !== 2'd0) begin errors++; $display("FAIL reset u%0d state got %0d want 0", i, st_o[i]); end
        end
        #1 w_rst = 1'b1;
    endtask

    task automatic test_count_up();
        for (int c = 0; c < 14; c++) begin
            if (c == 0) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
            else if (c == 1) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
            else cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
            for (int i = 0; i < 2; i++) begin
                checks++; if (bcd_o[i] !== exp_bcd(i)) begin errors++; $display("FAIL count_up c%0d u%0d bcd got %h want %h", c, i, bcd_o[i], exp_bcd(i)); end
                checks++; if (seg_o[i] !== exp_seg(i)) begin errors++; $display("FAIL count_up c%0d u%0d seg got %h want %h", c, i, seg_o[i], exp_seg(i)); end
                checks++; if (tc_o[i] !== m_tc[i]) begin errors++; $display("FAIL count_up c%0d u%0d tc got %b want %b", c, i, tc_o[i], m_tc[i]); end
                checks++; if (st_o[i] !== 2'(m_st[i])) begin errors++; $display("FAIL count_up c%0d u%0d state got %0d want %0d", c, i, st_o[i], m_st[i]); end
            end
        end
        checks++; if (bcd_o[0] !== 8'h12) begin errors++; $display("FAIL count_up_12 bcd got %h want 12", bcd_o[0]); end
        checks++; if (seg_o[0][14:8] !== 7'h06 || seg_o[0][6:0] !== 7'h5B) begin errors++; $display("FAIL count_up_12 seg got %h want x6/5B", seg_o[0]); end
    endtask

    task automatic test_wrap_up();
        logic [4:0] sc [7] = '{5'b01100, 5'b00110, 5'b10100, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
        for (int c = 0; c < 7; c++) begin
            cycle(sc[c][4], sc[c][3], sc[c][2], sc[c][1], 8'h98);
            for (int i = 0; i < 2; i++) begin
                checks++; if (bcd_o[i] !== exp_bcd(i)) begin errors++; $display("FAIL wrap_up c%0d u%0d bcd got %h want %h", c, i, bcd_o[i], exp_bcd(i)); end
                checks++; if (seg_o[i] !== exp_seg(i)) begin errors++; $display("FAIL wrap_up c%0d u%0d seg got %h want %h", c, i, seg_o[i], exp_seg(i)); end
                checks++; if (tc_o[i] !== m_tc[i]) begin errors++; $display("FAIL wrap_up c%0d u%0d tc got %b want %b", c, i, tc_o[i], m_tc[i]); end
                checks++; if (st_o[i] !== 2'(m_st[i])) begin errors++; $display("FAIL wrap_up c%0d u%0d state got %0d want %0d", c, i, st_o[i], m_st[i]); end
            end
        end
        checks++; if (st_o[1] !== 2'd3 || bcd_o[1] !== 8'h99) begin errors++; $display("FAIL wrap_stop u1 state/bcd got %0d/%h want 3/99", st_o[1], bcd_o[1]); end
    endtask

    task automatic test_down();
        // {start, pause, dir, load}
        logic [3:0] sc [11] = '{4'b0100, 4'b0001, 4'b1000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
        for (int c = 0; c < 11; c++) begin
            cycle(sc[c][3], sc[c][2], sc[c][1], sc[c][0], 8'h03);
            for (int i = 0; i < 2; i++) begin
                checks++; if (bcd_o[i] !== exp_bcd(i)) begin errors++; $display("FAIL down c%0d u%0d bcd got %h want %h", c, i, bcd_o[i], exp_bcd(i)); end
                checks++; if (seg_o[i] !== exp_seg(i)) begin errors++; $display("FAIL down c%0d u%0d seg got %h want %h", c, i, seg_o[i], exp_seg(i)); end
                checks++; if (tc_o[i] !== m_tc[i]) begin errors++; $display("FAIL down c%0d u%0d tc got %b want %b", c, i, tc_o[i], m_tc[i]); end
                checks++; if (st_o[i] !== 2'(m_st[i])) begin errors++; $display("FAIL down c%0d u%0d state got %0d want %0d", c, i, st_o[i], m_st[i]); end
            end
        end
    endtask

    task automatic test_pause_priority();
        // {start, pause, dir, load}
        logic [3:0] sc [10] = '{4'b0110, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                4'b0010, 4'b1011, 4'b1010, 4'b0011, 4'b0010};
        for (int c = 0; c < 10; c++) begin
            cycle(sc[c][3], sc[c][2], sc[c][1], sc[c][0], 8'h55);
            for (int i = 0; i < 2; i++) begin
                checks++; if (bcd_o[i] !== exp_bcd(i)) begin errors++; $display("FAIL pause c%0d u%0d bcd got %h want %h", c, i, bcd_o[i], exp_bcd(i)); end
                checks++; if (seg_o[i] !== exp_seg(i)) begin errors++; $display("FAIL pause c%0d u%0d seg got %h want %h", c, i, seg_o[i], exp_seg(i)); end
                checks++; if (tc_o[i] !== m_tc[i]) begin errors++; $display("FAIL pause c%0d u%0d tc got %b want %b", c, i, tc_o[i], m_tc[i]); end
                checks++; if (st_o[i] !== 2'(m_st[i])) begin errors++; $display("FAIL pause c%0d u%0d state got %0d want %0d", c, i, st_o[i], m_st[i]); end
            end
        end
    endtask

    task automatic test_clamp_blank();
        logic [7:0] lv [5] = '{8'h00, 8'hFA, 8'h05, 8'h05, 8'h05};
        logic [3:0] sc [5] = '{4'b0110, 4'b0011, 4'b0011, 4'b0010, 4'b1010};
        for (int c = 0; c < 5; c++) begin
            cycle(sc[c][3], sc[c][2], sc[c][1], sc[c][0], lv[c]);
            for (int i = 0; i < 2; i++) begin
                checks++; if (bcd_o[i] !== exp_bcd(i)) begin errors++; $display("FAIL clamp c%0d u%0d bcd got %h want %h", c, i, bcd_o[i], exp_bcd(i)); end
                checks++; if (seg_o[i] !== exp_seg(i)) begin errors++; $display("FAIL clamp c%0d u%0d seg got %h want %h", c, i, seg_o[i], exp_seg(i)); end
                checks++; if (tc_o[i] !== m_tc[i]) begin errors++; $display("FAIL clamp c%0d u%0d tc got %b want %b", c, i, tc_o[i], m_tc[i]); end
                checks++; if (st_o[i] !== 2'(m_st[i])) begin errors++; $display("FAIL clamp c%0d u%0d state got %0d want %0d", c, i, st_o[i], m_st[i]); end
            end
            if (c == 1) begin
                checks++; if (bcd_o[0] !== 8'h99) begin errors++; $display("FAIL clamp_FA bcd got %h want 99", bcd_o[0]); end
            end
            if (c == 2) begin
                checks++; if (seg_o[1] !== 16'hFF92) begin errors++; $display("FAIL lzb_05 seg got %h want FF92", seg_o[1]); end
            end
        end
    endtask

    task automatic test_random();
        logic st, pa, di, ld;
        logic [7:0] lb;
        for (int c = 0; c < 400; c++) begin
            st = ($urandom_range(0, 5) == 0);
            pa = ($urandom_range(0, 7) == 0);
            di = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 9) == 0);
            lb = 8'($urandom);
            if (c % 40 == 0) lb = 8'h99;
            if (c % 40 == 20) lb = 8'h00;
            cycle(st, pa, di, ld, lb);
            for (int i = 0; i < 2; i++) begin
                checks++; if (bcd_o[i] !== exp_bcd(i)) begin errors++; $display("FAIL random c%0d u%0d bcd got %h want %h", c, i, bcd_o[i], exp_bcd(i)); end
                checks++; if (seg_o[i] !== exp_seg(i)) begin errors++; $display("FAIL random c%0d u%0d seg got %h want %h", c, i, seg_o[i], exp_seg(i)); end
                checks++; if (tc_o[i] !== m_tc[i]) begin errors++; $display("FAIL random c%0d u%0d tc got %b want %b", c, i, tc_o[i], m_tc[i]); end
                checks++; if (st_o[i] !== 2'(m_st[i])) begin errors++; $display("FAIL random c%0d u%0d state got %0d want %0d", c, i, st_o[i], m_st[i]); end
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h47);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        i_start = 1'b0;
        checks++; if (bcd_o[0] !== 8'h47 || st_o[0] !== 2'd1) begin errors++; $display("FAIL arst_pre bcd/state got %h/%0d want 47/1", bcd_o[0], st_o[0]); end
        #3 w_rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (bcd_o[i] !== exp_bcd(i)) begin errors++; $display("FAIL arst u%0d bcd got %h want %h", i, bcd_o[i], exp_bcd(i)); end
            checks++; if (seg_o[i] !== exp_seg(i)) begin errors++; $display("FAIL arst u%0d seg got %h want %h", i, seg_o[i], exp_seg(i)); end
            checks++; if (tc_o[i] !== 1'b0) begin errors++; $display("FAIL arst u%0d tc got %b want 0", i, tc_o[i]); end
            checks++; if (st_o[i] !== 2'd0) begin errors++; $display("FAIL arst u%0d state got %0d want 0", i, st_o[i]); end
        end
        #2 w_rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            // preset was lost: a DONE-style restart is not reachable, IDLE holds 00
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
            for (int i = 0; i < 2; i++) begin
                checks++; if (bcd_o[i] !== exp_bcd(i)) begin errors++; $display("FAIL arst_post c%0d u%0d bcd got %h want %h", c, i, bcd_o[i], exp_bcd(i)); end
                checks++; if (seg_o[i] !== exp_seg(i)) begin errors++; $display("FAIL arst_post c%0d u%0d seg got %h want %h", c, i, seg_o[i], exp_seg(i)); end
                checks++; if (st_o[i] !== 2'(m_st[i])) begin errors++; $display("FAIL arst_post c%0d u%0d state got %0d want %0d", c, i, st_o[i], m_st[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_down();
        test_pause_priority();
        test_clamp_blank();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
